// File: rtl/rice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rice_pkg
//  Description : Shared constants and state encoding for the Rice decoder
//                control block. Both the control FSM and the leading-zero
//                counter take their default widths from here.
//  Revision    : 1.0  initial release
// ============================================================================
package rice_pkg;

    // Telemetry word width, Rice parameter width and largest legal quotient.
    localparam int RICE_WORD_W = 16;
    localparam int RICE_K_W    = 4;
    localparam int RICE_Q_MAX  = 31;

    // Bit buffer holds two words, MSB-aligned.
    localparam int RICE_BUF_W  = 2 * RICE_WORD_W;

    // Valid-bit count must represent 0..RICE_BUF_W inclusive.
    localparam int RICE_CNT_W  = $clog2(RICE_BUF_W + 1);

    // Decoded sample width and quotient accumulator width. The accumulator
    // has headroom above Q_MAX so an overflowing sum is still representable
    // and can be compared before it is committed.
    localparam int RICE_OUT_W  = 20;
    localparam int RICE_Q_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UNARY = 3'd1,
        ST_REM   = 3'd2,
        ST_OUT   = 3'd3,
        ST_ERR   = 3'd4
    } rice_state_e;

endpackage
`default_nettype wire

// File: rtl/rice_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : rice_lzc
//  Description : Combinational leading-zero counter with a valid-bit mask.
//                Only bits whose mask bit is set are considered; the count
//                is the number of zeros above the first valid '1' (MSB side).
//  Ports       : data  [W-1:0]  in   bit vector, MSB first
//                mask  [W-1:0]  in   1 = bit is valid
//                count [CW-1:0] out  leading zeros before the first valid '1'
//                found          out  a valid '1' exists (count is 0 if not)
//  Revision    : 1.0  initial release
// ============================================================================
module rice_lzc
    import rice_pkg::*;
#(
    parameter int W  = RICE_BUF_W,
    parameter int CW = RICE_CNT_W
) (
    input  logic [W-1:0]  data,
    input  logic [W-1:0]  mask,
    output logic [CW-1:0] count,
    output logic          found
);

    logic [W-1:0] w_hits;

    assign w_hits = data & mask;

    // Scan LSB to MSB; the last hit written is the most significant one.
    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (w_hits[i]) begin
                found = 1'b1;
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rice_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rice_decode_ctrl
//  Description : Rice (Golomb power-of-two) decoder control. Accepts a block
//                request, pulls MSB-first code words into a two-word bit
//                buffer, decodes unary quotient + k-bit remainder per sample
//                and presents (q << k) | r on a valid/ready output.
//  Ports       : clk, reset                 clock, async active-high reset
//                start, k_cfg, n_samples    block request and its parameters
//                in_data, in_valid, in_ready    code word input stream
//                out_data, out_valid, out_ready decoded sample output stream
//                busy                       state is not IDLE
//                done                       one-cycle block-complete pulse
//                err                        sticky quotient overflow
//  Revision    : 1.0  initial release
// ============================================================================
module rice_decode_ctrl
    import rice_pkg::*;
#(
    parameter int WORD_W = RICE_WORD_W,
    parameter int K_W    = RICE_K_W,
    parameter int Q_MAX  = RICE_Q_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [K_W-1:0]    k_cfg,
    input  logic [15:0]       n_samples,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [19:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_BUF_W = 2 * WORD_W;
    localparam int c_CNT_W = $clog2(c_BUF_W + 1);
    localparam int c_OUT_W = RICE_OUT_W;
    localparam int c_Q_W   = RICE_Q_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rice_state_e          r_state,  w_state_nxt;
    logic [c_BUF_W-1:0]   r_buf,    w_buf_nxt;
    logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [c_Q_W-1:0]     r_q,      w_q_nxt;
    logic [c_OUT_W-1:0]   r_rem,    w_rem_nxt;
    logic [K_W-1:0]       r_k,      w_k_nxt;
    logic [15:0]          r_n,      w_n_nxt;
    logic [15:0]          r_scnt,   w_scnt_nxt;
    logic                 r_done,   w_done_nxt;
    logic                 r_err,    w_err_nxt;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [c_BUF_W-1:0]   w_mask;
    logic [c_CNT_W-1:0]   w_lz;
    logic                 w_found;
    logic [c_CNT_W-1:0]   w_lz_plus1;
    logic [c_CNT_W-1:0]   w_app_sh;
    logic [c_BUF_W-1:0]   w_app;
    logic [c_CNT_W-1:0]   w_k_ext;
    logic [c_OUT_W-1:0]   w_rem_bits;
    logic [c_Q_W-1:0]     w_q_plus_lz;
    logic [c_Q_W-1:0]     w_q_plus_cnt;
    logic [15:0]          w_scnt_inc;
    logic                 w_in_ready;
    logic                 w_accept;

    // Top r_cnt bits of the buffer are valid. A shift by the full width
    // yields an all-ones mask when the buffer is full.
    assign w_mask       = ~({c_BUF_W{1'b1}} >> r_cnt);

    // Incoming word lands directly below the current valid bits.
    assign w_app_sh     = c_CNT_W'(c_BUF_W - WORD_W) - r_cnt;
    assign w_app        = c_BUF_W'(in_data) << w_app_sh;

    // Top k bits of the buffer. k = 0 shifts by the full width, giving 0.
    assign w_k_ext      = c_CNT_W'(r_k);
    assign w_rem_bits   = c_OUT_W'(r_buf >> (c_CNT_W'(c_BUF_W) - w_k_ext));

    assign w_lz_plus1   = w_lz + c_CNT_W'(1);
    assign w_q_plus_lz  = r_q + c_Q_W'(w_lz);
    assign w_q_plus_cnt = r_q + c_Q_W'(r_cnt);
    assign w_scnt_inc   = r_scnt + 16'd1;

    // Refill is only offered while decoding and while a whole word fits.
    assign w_in_ready   = ((r_state == ST_UNARY) || (r_state == ST_REM)) &&
                          (r_cnt <= c_CNT_W'(WORD_W));
    assign w_accept     = in_valid && w_in_ready;

    rice_lzc #(
        .W  (c_BUF_W),
        .CW (c_CNT_W)
    ) u_lzc (
        .data  (r_buf),
        .mask  (w_mask),
        .count (w_lz),
        .found (w_found)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_k_nxt     = r_k;
        w_n_nxt     = r_n;
        w_scnt_nxt  = r_scnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_k_nxt    = k_cfg;
                    w_n_nxt    = n_samples;
                    w_scnt_nxt = '0;
                    w_buf_nxt  = '0;
                    w_cnt_nxt  = '0;
                    w_q_nxt    = '0;
                    w_rem_nxt  = '0;
                    if (n_samples == 16'd0) begin
                        // Empty block completes without leaving IDLE.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNARY;
                    end
                end
            end

            ST_UNARY: begin
                if (w_accept) begin
                    w_buf_nxt = r_buf | w_app;
                    w_cnt_nxt = r_cnt + c_CNT_W'(WORD_W);
                end else if (w_found) begin
                    if (w_q_plus_lz > c_Q_W'(Q_MAX)) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        // Drop the zeros and the terminating '1'.
                        w_q_nxt     = w_q_plus_lz;
                        w_buf_nxt   = r_buf << w_lz_plus1;
                        w_cnt_nxt   = r_cnt - w_lz_plus1;
                        w_state_nxt = ST_REM;
                    end
                end else begin
                    // Every valid bit is a zero: fold them into q.
                    if (w_q_plus_cnt > c_Q_W'(Q_MAX)) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_q_nxt   = w_q_plus_cnt;
                        w_buf_nxt = '0;
                        w_cnt_nxt = '0;
                    end
                end
            end

            ST_REM: begin
                if (w_accept) begin
                    w_buf_nxt = r_buf | w_app;
                    w_cnt_nxt = r_cnt + c_CNT_W'(WORD_W);
                end else if (r_cnt >= w_k_ext) begin
                    w_rem_nxt   = w_rem_bits;
                    w_buf_nxt   = r_buf << w_k_ext;
                    w_cnt_nxt   = r_cnt - w_k_ext;
                    w_state_nxt = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    w_q_nxt    = '0;
                    w_rem_nxt  = '0;
                    w_scnt_nxt = w_scnt_inc;
                    if (w_scnt_inc == r_n) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_UNARY;
                    end
                end
            end

            ST_ERR: begin
                // Terminal until reset.
                w_state_nxt = ST_ERR;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_scnt  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_k     <= w_k_nxt;
            r_n     <= w_n_nxt;
            r_scnt  <= w_scnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_OUT);
    assign out_data  = out_valid ? ((c_OUT_W'(r_q) << r_k) | r_rem) : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rice_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rice_decode_ctrl
//  Description : Directed self-checking bench for rice_decode_ctrl. Expected
//                samples are queued when a block is started and compared as
//                the decoder hands them out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rice_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  k_cfg;
    logic [15:0] n_samples;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          out_cnt  = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    rice_decode_ctrl #(
        .WORD_W (16),
        .K_W    (4),
        .Q_MAX  (31)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_cfg     (k_cfg),
        .n_samples (n_samples),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every handshake pops one expectation.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            out_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected: observed out_data %0d expected no sample", out_data);
            end
            if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] k, input logic [15:0] n);
        start     = 1'b1;
        k_cfg     = k;
        n_samples = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int budget, output bit acc);
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < budget && !acc; c++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            tick();
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
    endtask

    initial begin
        bit acc;
        int d0;
        int o0;

        reset     = 1'b1;
        start     = 1'b0;
        k_cfg     = '0;
        n_samples = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic decode: 0001|01 -> 13, 1|10 -> 2, exactly one done.
        d0 = done_cnt;
        exp_q.push_back(20'd13);
        exp_q.push_back(20'd2);
        do_start(4'd2, 16'd2);
        check("basic_busy", 32'(busy), 32'd1);
        send_word(16'h1700, 20, acc);
        check("basic_accept", 32'(acc), 32'd1);
        wait_done("basic_done", 40);
        check("basic_done_cleared", 32'(done), 32'd0);
        tick();
        tick();
        check("basic_done_once", 32'(done_cnt - d0), 32'd1);
        check("basic_idle", 32'(busy), 32'd0);
        check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

        // Quotient spanning a word boundary: 16 zeros then '1', k = 0 -> 16.
        exp_q.push_back(20'd16);
        do_start(4'd0, 16'd1);
        send_word(16'h0000, 20, acc);
        send_word(16'h8000, 20, acc);
        check("span_accept", 32'(acc), 32'd1);
        wait_done("span_done", 40);
        check("span_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty block: done pulse, no output, stays idle.
        o0 = out_cnt;
        do_start(4'd1, 16'd0);
        check("n0_busy", 32'(busy), 32'd0);
        wait_done("n0_done", 3);
        tick();
        check("n0_no_output", 32'(out_cnt - o0), 32'd0);

        // Start while busy is ignored: k stays 2 and n stays 1.
        exp_q.push_back(20'd13);
        do_start(4'd2, 16'd1);
        do_start(4'd0, 16'd5);
        check("busy_start_busy", 32'(busy), 32'd1);
        send_word(16'h1700, 20, acc);
        wait_done("busy_start_done", 40);
        check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: two words buffered, output stalled for 5 cycles.
        exp_q.push_back(20'd13);
        exp_q.push_back(20'd2);
        exp_q.push_back(20'd41);
        out_ready = 1'b0;
        do_start(4'd2, 16'd3);
        send_word(16'h1700, 20, acc);
        send_word(16'h1700, 20, acc);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'd13);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_done("bp_done", 80);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for remainder bits (k = 15, only 12 left).
        do_start(4'd15, 16'd1);
        send_word(16'h1000, 20, acc);
        tick();
        tick();
        tick();
        check("rem_wait_busy", 32'(busy), 32'd1);
        check("rem_wait_out_valid", 32'(out_valid), 32'd0);
        #2;
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        tick();
        reset = 1'b0;
        tick();
        check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.push_back(20'd1);
        do_start(4'd3, 16'd1);
        send_word(16'h9000, 20, acc);
        wait_done("after_reset_done", 40);
        check("after_reset_sb_empty", 32'(exp_q.size()), 32'd0);

        // Quotient overflow: 32 zeros exceed Q_MAX = 31.
        o0 = out_cnt;
        do_start(4'd0, 16'd1);
        send_word(16'h0000, 20, acc);
        send_word(16'h0000, 20, acc);
        check("ovf_second_accept", 32'(acc), 32'd1);
        send_word(16'h0000, 10, acc);
        check("ovf_third_refused", 32'(acc), 32'd0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        check("ovf_out_valid", 32'(out_valid), 32'd0);
        check("ovf_busy", 32'(busy), 32'd1);
        do_start(4'd0, 16'd1);
        tick();
        tick();
        check("ovf_err_sticky", 32'(err), 32'd1);
        check("ovf_no_output", 32'(out_cnt - o0), 32'd0);
        reset = 1'b1;
        #1;
        check_idle_outputs("ovf_reset");
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
